wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 exu_valid  input  1  execute-stage result present.
REQ-004 exu_ready  output  1  wb_unit accepts execute result this cycle.
REQ-005 exu_rfwe  input  1  execute result writes the register file.
REQ-006 exu_rdaddr  input  5  execute destination register.
REQ-007 exu_result  input  64  execute result value.
REQ-008 lsu_valid  input  1  load result present.
REQ-009 lsu_ready  output  1  wb_unit accepts load result this cycle.
REQ-010 lsu_rdaddr  input  5  load destination register.
REQ-011 lsu_rdata  input  64  raw aligned doubleword from memory.
REQ-012 lsu_funct3  input  3  load type (RV64 encoding).
REQ-013 lsu_addr_lo  input  3  byte offset of load address.
REQ-014 RFwe  output  1  register-file write enable.
REQ-015 rdaddr  output  5  register-file write address.
REQ-016 rd  output  64  register-file write data.
REQ-017 wb_valid  output  1  writeback-complete request to register file.
REQ-018 wb_finish  input  1  register-file acknowledge, one-cycle pulse.
REQ-019 load_err  output  1  one-cycle pulse: reserved lsu_funct3 (111) written back.
REQ-020 instret  output  64  count of acknowledged writebacks.

Function
REQ-021 FSM states IDLE, WRITE, WAIT; reset state IDLE.
REQ-022 lsu_ready = (state==IDLE); exu_ready = (state==IDLE) && !lsu_valid; load has priority over execute.
REQ-023 IDLE: on lsu_valid, latch load fields and go to WRITE; else on exu_valid, latch execute fields and go to WRITE; else stay.
REQ-024 WRITE (exactly one cycle): drive rdaddr/rd from latched entry, wb_valid=1, RFwe=1 only if entry writes and rdaddr!=0; next state WAIT.
REQ-025 WAIT: RFwe=0, wb_valid=0, rdaddr/rd hold; on wb_finish=1 go to IDLE and increment instret by 1 (wraps at 2^64-1 -> 0).
REQ-026 wb_finish while in IDLE or WRITE is ignored; no count, no state change.
REQ-027 Load entries always write (rfwe=1); value computed at accept time: s = lsu_rdata >> (8*lsu_addr_lo).
REQ-028 funct3 000 LB: sign-extend s[7:0]; 001 LH: sign-extend s[15:0]; 010 LW: sign-extend s[31:0]; 011 LD: s; 100 LBU/101 LHU/110 LWU: zero-extend 8/16/32 bits.
REQ-029 funct3 111: rd=0, RFwe still asserted (unless rdaddr==0), load_err=1 during the WRITE cycle only.
REQ-030 Misaligned offsets are not checked; value follows REQ-027 shift (upper bits zero-filled before extension).
REQ-031 Minimum turnaround: accept N, WRITE N+1, wb_finish N+2, IDLE N+3, next accept N+3.
REQ-032 Simultaneous lsu_valid and exu_valid in IDLE: load accepted, exu_ready=0, execute result held by producer.

Reset
REQ-033 rst sampled high: state IDLE, RFwe=0, wb_valid=0, rdaddr=0, rd=0, load_err=0, instret=0, latched entry discarded.
REQ-034 rst in WRITE or WAIT abandons the entry; a later wb_finish for it is ignored (REQ-026).
REQ-035 exu_ready and lsu_ready are 0 during a cycle with rst=1.

Verification
REQ-036 exu_valid, rfwe=1, rdaddr=5, result=0x1234 -> next cycle RFwe=1, wb_valid=1, rdaddr=5, rd=0x1234; wb_finish one cycle later -> instret=1.
REQ-037 lsu LB, rdata=0x0000_0000_0000_8000, addr_lo=1 -> rd=0xFFFF_FFFF_FFFF_FF80; LBU same -> rd=0x80.
REQ-038 lsu LW, rdata=0x8000_0000_0000_0000 ... addr_lo=4, rdata=0x8765_4321_0000_0000 -> rd=0xFFFF_FFFF_8765_4321; LWU -> 0x8765_4321.
REQ-039 exu_valid and lsu_valid same cycle -> lsu_ready=1, exu_ready=0, load written first; execute written after wb_finish.
REQ-040 exu rdaddr=0, rfwe=1 -> RFwe=0, wb_valid=1, instret increments on wb_finish; funct3=111 -> rd=0, load_err pulse.
REQ-041 rst asserted in WAIT then wb_finish pulse -> state IDLE, instret=0, no RFwe, no count.

Source files
------------

// File: rtl/wb_unit.sv
// Writeback unit: arbitrates load and execute results into a single register-file write,
// extends load data by type, and counts acknowledged writebacks.
module wb_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic        exu_rfwe,
    input  logic [4:0]  exu_rdaddr,
    input  logic [63:0] exu_result,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rdaddr,
    input  logic [63:0] lsu_rdata,
    input  logic [2:0]  lsu_funct3,
    input  logic [2:0]  lsu_addr_lo,
    output logic        RFwe,
    output logic [4:0]  rdaddr,
    output logic [63:0] rd,
    output logic        wb_valid,
    input  logic        wb_finish,
    output logic        load_err,
    output logic [63:0] instret
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]  state;
    logic        ent_rfwe;
    logic        ent_err;
    logic [63:0] shifted;
    logic [63:0] load_value;

    // A producer's valid/ready pair transfers on a cycle where both are high; the
    // producer holds its payload stable until then. Load wins over execute.
    assign lsu_ready = (state == S_IDLE) && !rst;
    assign exu_ready = (state == S_IDLE) && !rst && !lsu_valid;

    assign wb_valid = (state == S_WRITE);
    assign RFwe     = (state == S_WRITE) && ent_rfwe && (rdaddr != 5'd0);
    assign load_err = (state == S_WRITE) && ent_err;

    assign shifted = lsu_rdata >> {lsu_addr_lo, 3'b000};

    always_comb begin
        load_value = 64'd0;
        case (lsu_funct3)
            3'b000:  load_value = {{56{shifted[7]}}, shifted[7:0]};
            3'b001:  load_value = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_value = {{32{shifted[31]}}, shifted[31:0]};
            3'b011:  load_value = shifted;
            3'b100:  load_value = {56'd0, shifted[7:0]};
            3'b101:  load_value = {48'd0, shifted[15:0]};
            3'b110:  load_value = {32'd0, shifted[31:0]};
            default: load_value = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ent_rfwe <= 1'b0;
            ent_err  <= 1'b0;
            rdaddr   <= 5'd0;
            rd       <= 64'd0;
            instret  <= 64'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lsu_valid) begin
                        state    <= S_WRITE;
                        ent_rfwe <= 1'b1;
                        ent_err  <= (lsu_funct3 == 3'b111);
                        rdaddr   <= lsu_rdaddr;
                        rd       <= load_value;
                    end else if (exu_valid) begin
                        state    <= S_WRITE;
                        ent_rfwe <= exu_rfwe;
                        ent_err  <= 1'b0;
                        rdaddr   <= exu_rdaddr;
                        rd       <= exu_result;
                    end
                end
                S_WRITE: state <= S_WAIT;
                S_WAIT: begin
                    // Only an acknowledge seen here retires the entry.
                    if (wb_finish) begin
                        state   <= S_IDLE;
                        instret <= instret + 64'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: linear steps with hand-computed expectations checked
// by immediate assertions.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, exu_ready, exu_rfwe;
    logic [4:0]  exu_rdaddr;
    logic [63:0] exu_result;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rdaddr;
    logic [63:0] lsu_rdata;
    logic [2:0]  lsu_funct3, lsu_addr_lo;
    logic        RFwe, wb_valid, wb_finish, load_err;
    logic [4:0]  rdaddr;
    logic [63:0] rd, instret;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_instret = 64'd0;

    always #5 clk = ~clk;

    wb_unit dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rfwe(exu_rfwe),
        .exu_rdaddr(exu_rdaddr), .exu_result(exu_result),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rdaddr(lsu_rdaddr),
        .lsu_rdata(lsu_rdata), .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
        .RFwe(RFwe), .rdaddr(rdaddr), .rd(rd), .wb_valid(wb_valid),
        .wb_finish(wb_finish), .load_err(load_err), .instret(instret)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one load for the accept cycle and leaves the unit in WRITE.
    task automatic do_load(input logic [2:0] f3, input logic [2:0] lo,
                           input logic [63:0] data, input logic [4:0] ra);
        lsu_valid = 1'b1; lsu_funct3 = f3; lsu_addr_lo = lo;
        lsu_rdata = data; lsu_rdaddr = ra;
        tick();
        lsu_valid = 1'b0;
    endtask

    task automatic do_exu(input logic we, input logic [4:0] ra, input logic [63:0] res);
        exu_valid = 1'b1; exu_rfwe = we; exu_rdaddr = ra; exu_result = res;
        tick();
        exu_valid = 1'b0;
    endtask

    // From WRITE: step to WAIT, then acknowledge.
    task automatic finish_entry();
        tick();
        wb_finish = 1'b1;
        tick();
        wb_finish = 1'b0;
        exp_instret = exp_instret + 64'd1;
    endtask

    initial begin
        rst = 1'b1; exu_valid = 1'b0; exu_rfwe = 1'b0; exu_rdaddr = '0; exu_result = '0;
        lsu_valid = 1'b0; lsu_rdaddr = '0; lsu_rdata = '0; lsu_funct3 = '0;
        lsu_addr_lo = '0; wb_finish = 1'b0;
        tick(); tick();
        chk("rst_rfwe", RFwe, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_rdaddr", rdaddr, 0);
        chk("rst_rd", rd, 0);
        chk("rst_lerr", load_err, 0);
        chk("rst_instret", instret, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_exu_ready", exu_ready, 0);
        rst = 1'b0; #1;
        chk("idle_lsu_ready", lsu_ready, 1);
        chk("idle_exu_ready", exu_ready, 1);

        // Basic execute writeback.
        do_exu(1'b1, 5'd5, 64'h1234);
        chk("exu_rfwe", RFwe, 1);
        chk("exu_wbv", wb_valid, 1);
        chk("exu_rdaddr", rdaddr, 5);
        chk("exu_rd", rd, 64'h1234);
        chk("write_lsu_ready", lsu_ready, 0);
        tick();
        chk("wait_wbv", wb_valid, 0);
        chk("wait_rfwe", RFwe, 0);
        chk("wait_rd_hold", rd, 64'h1234);
        wb_finish = 1'b1; tick(); wb_finish = 1'b0;
        exp_instret = exp_instret + 64'd1;
        chk("instret_1", instret, 1);
        chk("back_idle", lsu_ready, 1);

        // Load extensions.
        do_load(3'b000, 3'd1, 64'h8000, 5'd1);
        chk("lb_rd", rd, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_rfwe", RFwe, 1);
        finish_entry();
        do_load(3'b100, 3'd1, 64'h8000, 5'd1);
        chk("lbu_rd", rd, 64'h80);
        finish_entry();
        do_load(3'b010, 3'd4, 64'h8765_4321_0000_0000, 5'd2);
        chk("lw_rd", rd, 64'hFFFF_FFFF_8765_4321);
        finish_entry();
        do_load(3'b110, 3'd4, 64'h8765_4321_0000_0000, 5'd2);
        chk("lwu_rd", rd, 64'h8765_4321);
        finish_entry();
        do_load(3'b011, 3'd2, 64'h1122_3344_5566_7788, 5'd3);
        chk("ld_shift_rd", rd, 64'h0000_1122_3344_5566);
        finish_entry();
        do_load(3'b001, 3'd0, 64'hFFFF_0000_0000_8001, 5'd3);
        chk("lh_rd", rd, 64'hFFFF_FFFF_FFFF_8001);
        finish_entry();
        do_load(3'b101, 3'd7, 64'hAB00_0000_0000_0000, 5'd3);
        chk("lhu_misalign_rd", rd, 64'hAB);
        finish_entry();
        chk("instret_8", instret, exp_instret);

        // Simultaneous producers: load first, execute held.
        lsu_valid = 1'b1; lsu_funct3 = 3'b011; lsu_addr_lo = 3'd0;
        lsu_rdata = 64'hAA; lsu_rdaddr = 5'd3;
        exu_valid = 1'b1; exu_rfwe = 1'b1; exu_rdaddr = 5'd7; exu_result = 64'h55;
        #1;
        chk("both_lsu_ready", lsu_ready, 1);
        chk("both_exu_ready", exu_ready, 0);
        tick();
        lsu_valid = 1'b0;
        chk("both_load_rdaddr", rdaddr, 3);
        chk("both_load_rd", rd, 64'hAA);
        chk("both_write_exu_ready", exu_ready, 0);
        finish_entry();
        chk("held_exu_ready", exu_ready, 1);
        tick();
        exu_valid = 1'b0;
        chk("held_exu_rdaddr", rdaddr, 7);
        chk("held_exu_rd", rd, 64'h55);
        chk("held_exu_rfwe", RFwe, 1);
        finish_entry();

        // x0 destination and non-writing execute still retire.
        do_exu(1'b1, 5'd0, 64'hDEAD);
        chk("x0_rfwe", RFwe, 0);
        chk("x0_wbv", wb_valid, 1);
        finish_entry();
        do_exu(1'b0, 5'd4, 64'hBEEF);
        chk("nowe_rfwe", RFwe, 0);
        finish_entry();
        chk("instret_x0", instret, exp_instret);

        // Reserved load type.
        do_load(3'b111, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9);
        chk("err_rd", rd, 0);
        chk("err_rfwe", RFwe, 1);
        chk("err_pulse", load_err, 1);
        tick();
        chk("err_pulse_end", load_err, 0);
        wb_finish = 1'b1; tick(); wb_finish = 1'b0;
        exp_instret = exp_instret + 64'd1;

        // Acknowledge outside WAIT is ignored.
        wb_finish = 1'b1; tick(); wb_finish = 1'b0;
        chk("idle_finish_ignored", instret, exp_instret);
        do_exu(1'b1, 5'd6, 64'h77);
        wb_finish = 1'b1; tick(); wb_finish = 1'b0;
        chk("write_finish_ignored", instret, exp_instret);
        chk("still_wait", lsu_ready, 0);
        wb_finish = 1'b1; tick(); wb_finish = 1'b0;
        exp_instret = exp_instret + 64'd1;
        chk("instret_after", instret, exp_instret);

        // Reset during WAIT abandons the entry.
        do_exu(1'b1, 5'd8, 64'h99);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        wb_finish = 1'b1; tick(); wb_finish = 1'b0;
        chk("rstwait_instret", instret, 0);
        chk("rstwait_rfwe", RFwe, 0);
        chk("rstwait_rd", rd, 0);
        chk("rstwait_idle", lsu_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
